// File: rtl/pulse_window_counter.sv
// pulse_window_counter: counts single-cycle event pulses over a programmable
// window of clkb cycles and publishes a saturated count, an overflow flag and
// a threshold alarm at the end of every completed window.
module pulse_window_counter #(
  parameter int CNT_W = 8,
  parameter int WIN_W = 16
) (
  input  logic             clkb,
  input  logic             rstb,
  input  logic             pulseb,
  input  logic             enable,
  input  logic [WIN_W-1:0] win_len,
  input  logic [CNT_W-1:0] threshold,
  output logic [CNT_W-1:0] count_out,
  output logic             count_valid,
  output logic             overflow,
  output logic             alarm,
  output logic             running
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] ACC_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [WIN_W-1:0] win_len_q, win_len_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic             ovf_acc_q, ovf_acc_d;
  logic [CNT_W-1:0] count_out_q, count_out_d;
  logic             count_valid_q, count_valid_d;
  logic             overflow_q, overflow_d;
  logic             alarm_q, alarm_d;

  // Accumulator value including this cycle's pulse, clamped at the maximum.
  logic             acc_at_max;
  logic             sat_hit;
  logic [CNT_W-1:0] acc_sat;
  logic             last_cycle;

  assign acc_at_max = (acc_q == ACC_MAX);
  assign sat_hit    = acc_at_max & pulseb;
  assign acc_sat    = acc_at_max ? ACC_MAX : (acc_q + {{(CNT_W-1){1'b0}}, pulseb});
  // win_len_q is never zero while in RUN, so the subtraction cannot wrap there.
  assign last_cycle = (win_cnt_q == (win_len_q - {{(WIN_W-1){1'b0}}, 1'b1}));

  // State and datapath registers; reset clears every output immediately.
  always_ff @(posedge clkb or negedge rstb) begin
    if (!rstb) begin
      state_q       <= IDLE;
      win_cnt_q     <= '0;
      win_len_q     <= '0;
      acc_q         <= '0;
      ovf_acc_q     <= 1'b0;
      count_out_q   <= '0;
      count_valid_q <= 1'b0;
      overflow_q    <= 1'b0;
      alarm_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      win_cnt_q     <= win_cnt_d;
      win_len_q     <= win_len_d;
      acc_q         <= acc_d;
      ovf_acc_q     <= ovf_acc_d;
      count_out_q   <= count_out_d;
      count_valid_q <= count_valid_d;
      overflow_q    <= overflow_d;
      alarm_q       <= alarm_d;
    end
  end

  // Next-state logic: window sequencing, accumulation and end-of-window publish.
  always_comb begin
    state_d       = state_q;
    win_cnt_d     = win_cnt_q;
    win_len_d     = win_len_q;
    acc_d         = acc_q;
    ovf_acc_d     = ovf_acc_q;
    count_out_d   = count_out_q;
    count_valid_d = 1'b0;
    overflow_d    = overflow_q;
    alarm_d       = alarm_q;

    unique case (state_q)
      IDLE: begin
        win_cnt_d = '0;
        acc_d     = '0;
        ovf_acc_d = 1'b0;
        if (enable && (win_len != '0)) begin
          win_len_d = win_len;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (!enable) begin
          // Abort: the partial window is discarded, published results hold.
          state_d   = IDLE;
          win_cnt_d = '0;
          acc_d     = '0;
          ovf_acc_d = 1'b0;
        end else if (last_cycle) begin
          // A pulse on the final cycle still belongs to this window.
          count_out_d   = acc_sat;
          overflow_d    = ovf_acc_q | sat_hit;
          alarm_d       = (acc_sat >= threshold);
          count_valid_d = 1'b1;
          win_cnt_d     = '0;
          acc_d         = '0;
          ovf_acc_d     = 1'b0;
          if (win_len != '0) begin
            win_len_d = win_len;
          end else begin
            state_d = IDLE;
          end
        end else begin
          win_cnt_d = win_cnt_q + {{(WIN_W-1){1'b0}}, 1'b1};
          acc_d     = acc_sat;
          ovf_acc_d = ovf_acc_q | sat_hit;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign count_out   = count_out_q;
  assign count_valid = count_valid_q;
  assign overflow    = overflow_q;
  assign alarm       = alarm_q;
  assign running     = (state_q == RUN);

endmodule

// File: tb/tb_pulse_window_counter.sv
// Bench for pulse_window_counter: random stimulus, an event-counting reference
// model feeding a result queue, and a monitor that checks every DUT cycle.
module tb_pulse_window_counter;

  localparam int CNT_W = 4;
  localparam int WIN_W = 16;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clkb = 1'b0;
  logic             rstb = 1'b0;
  logic             pulseb = 1'b0;
  logic             enable = 1'b0;
  logic [WIN_W-1:0] win_len = '0;
  logic [CNT_W-1:0] threshold = '0;
  logic [CNT_W-1:0] count_out;
  logic             count_valid;
  logic             overflow;
  logic             alarm;
  logic             running;

  pulse_window_counter #(.CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .clkb        (clkb),
    .rstb        (rstb),
    .pulseb      (pulseb),
    .enable      (enable),
    .win_len     (win_len),
    .threshold   (threshold),
    .count_out   (count_out),
    .count_valid (count_valid),
    .overflow    (overflow),
    .alarm       (alarm),
    .running     (running)
  );

  always #5 clkb = ~clkb;

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic             alm;
  } res_t;

  res_t exp_q[$];
  res_t m_last = '0;
  res_t m_res;
  res_t m_e;
  bit   m_run = 1'b0;
  int   m_k = 0;
  int   m_n = 0;
  int   m_len = 0;
  int   n_vec = 0;
  int   n_err = 0;
  bit   sim_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counts raw events per window with an unbounded integer,
  // then derives the saturated count, overflow and alarm when the window closes.
  always @(posedge clkb) begin
    if (rstb) begin
      if (!m_run) begin
        if (enable && win_len != 0) begin
          m_run = 1'b1;
          m_len = int'(win_len);
          m_k   = 0;
          m_n   = 0;
        end
      end else if (!enable) begin
        m_run = 1'b0;
      end else begin
        m_n += int'(pulseb);
        if (m_k == m_len - 1) begin
          m_res.cnt = (m_n > MAXC) ? CNT_W'(MAXC) : CNT_W'(m_n);
          m_res.ovf = (m_n > MAXC);
          m_res.alm = (int'(m_res.cnt) >= int'(threshold));
          exp_q.push_back(m_res);
          m_last = m_res;
          m_n = 0;
          m_k = 0;
          if (win_len != 0) m_len = int'(win_len);
          else m_run = 1'b0;
        end else begin
          m_k++;
        end
      end
    end
  end

  always @(negedge rstb) begin
    m_run = 1'b0;
    m_last = '0;
    exp_q.delete();
  end

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clkb) begin
    if (!sim_done) begin
      if (!rstb) begin
        chk("reset_outputs", {23'd0, count_out, count_valid, overflow, alarm, running}, 32'd0);
      end else begin
        chk("running", running, m_run);
        if (count_valid) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL spurious_count_valid: got 1 expected 0 at %0t", $time);
          end else begin
            m_e = exp_q.pop_front();
            chk("count_out", count_out, m_e.cnt);
            chk("overflow", overflow, m_e.ovf);
            chk("alarm", alarm, m_e.alm);
          end
        end else begin
          if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL missing_count_valid: got 0 expected 1 at %0t", $time);
            exp_q.delete();
          end
          chk("hold_count_out", count_out, m_last.cnt);
          chk("hold_overflow", overflow, m_last.ovf);
          chk("hold_alarm", alarm, m_last.alm);
        end
      end
    end
  end

  task automatic cyc(input bit en, input int len, input int thr, input int pct);
    @(posedge clkb);
    #1;
    enable    = en;
    win_len   = WIN_W'(len);
    threshold = CNT_W'(thr);
    pulseb    = ($urandom_range(99) < pct);
  endtask

  initial begin
    repeat (3) @(posedge clkb);
    #1;
    rstb = 1'b1;

    // Fixed pulse pattern at window positions 0, 5 and 9 of a 10-cycle window.
    cyc(1'b1, 10, 3, 0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clkb);
      #1;
      pulseb = ((i % 10) == 0) || ((i % 10) == 5) || ((i % 10) == 9);
    end
    // Threshold alarm around the boundary: 3 pulses then 2 pulses per window.
    for (int i = 0; i < 20; i++) begin
      @(posedge clkb);
      #1;
      pulseb = (i < 10) ? ((i % 10) < 3) : ((i % 10) < 2);
    end

    // Saturation: long window with dense pulses, then a sparse short window.
    for (int i = 0; i < 64; i++) cyc(1'b1, 32, 10, 80);
    for (int i = 0; i < 40; i++) cyc(1'b1, 8, 2, 25);

    // Abort mid-window, hold previous results, restart.
    for (int i = 0; i < 5; i++) cyc(1'b1, 10, 3, 40);
    cyc(1'b0, 10, 3, 40);
    for (int i = 0; i < 3; i++) cyc(1'b0, 10, 3, 40);
    for (int i = 0; i < 25; i++) cyc(1'b1, 10, 3, 40);

    // Illegal window length keeps the block idle; then single-cycle windows.
    cyc(1'b0, 0, 1, 50);
    for (int i = 0; i < 10; i++) cyc(1'b1, 0, 1, 50);
    for (int i = 0; i < 30; i++) cyc(1'b1, 1, 1, 50);
    // Window length dropped to zero at a window end returns to idle.
    for (int i = 0; i < 6; i++) cyc(1'b1, 0, 1, 50);

    // Asynchronous reset in the middle of a window.
    for (int i = 0; i < 7; i++) cyc(1'b1, 10, 2, 50);
    @(posedge clkb);
    #3;
    rstb = 1'b0;
    #1;
    chk("async_reset_now", {23'd0, count_out, count_valid, overflow, alarm, running}, 32'd0);
    repeat (2) @(posedge clkb);
    #1;
    rstb = 1'b1;
    for (int i = 0; i < 25; i++) cyc(1'b1, 10, 2, 50);

    // Random traffic: varying lengths, thresholds, densities, aborts.
    for (int i = 0; i < 1500; i++) begin
      int len;
      len = ($urandom_range(19) == 0) ? int'($urandom_range(20, 40)) : int'($urandom_range(0, 12));
      if ($urandom_range(9) != 0) len = int'(win_len == 0 ? WIN_W'(3) : win_len);
      if ($urandom_range(29) == 0) len = int'($urandom_range(0, 12));
      cyc($urandom_range(24) != 0, len, int'($urandom_range(MAXC)), int'($urandom_range(10, 90)));
    end

    for (int i = 0; i < 4; i++) cyc(1'b0, 5, 0, 0);
    @(posedge clkb);
    #1;
    chk("queue_drained", exp_q.size(), 32'd0);
    sim_done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
